tiny16_mem_arbiter: RTL

//  Shares one single-port 16-bit memory between two bus masters. Master 0 is the

---
 rtl/tiny16_bus_pkg.sv | 20 ++
 rtl/tiny16_rr_pick.sv | 21 ++
 rtl/tiny16_mem_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tiny16_bus_pkg.sv
// Shared definitions for the tiny16 bus: data width, master indices and the
// access-sequencer state encoding.
package tiny16_bus_pkg;

  localparam int BUS_W    = 16;
  localparam int M_CORE   = 0;
  localparam int M_LOADER = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // One-hot grant vector for a master index (bit 0 = core, bit 1 = loader).
  function automatic logic [1:0] idx_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tiny16_rr_pick.sv
// Two-way request picker: a lone requester always wins; a tie goes to the master
// that was not served last, or always to master 0 when fixed_prio is set.
module tiny16_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // last=1 means master 1 was served most recently, so master 0 is next.
      2'b11:   grant = (fixed_prio || last) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/tiny16_mem_arbiter.sv
// Two-master arbiter for a single-port 16-bit SRAM with programmable wait states.
// Each access runs IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE -> IDLE.
module tiny16_mem_arbiter
  import tiny16_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          FIXED_PRIO  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BUS_W-1:0] m0_address,
  input  logic [BUS_W-1:0] m0_data_out,
  input  logic             m0_rd,
  input  logic             m0_wr,
  output logic [BUS_W-1:0] m0_data_in,
  output logic             m0_ready,
  input  logic [BUS_W-1:0] m1_address,
  input  logic [BUS_W-1:0] m1_data_out,
  input  logic             m1_rd,
  input  logic             m1_wr,
  output logic [BUS_W-1:0] m1_data_in,
  output logic             m1_ready,
  output logic [BUS_W-1:0] mem_address,
  output logic [BUS_W-1:0] mem_data_out,
  input  logic [BUS_W-1:0] mem_data_in,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [1:0]       grant,
  output logic             err
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  logic [1:0]            rd_n;
  logic [1:0]            wr_n;
  logic [1:0][BUS_W-1:0] addr_in;
  logic [1:0][BUS_W-1:0] wdata_in;
  logic [1:0]            req;
  logic [1:0]            both_low;
  logic [1:0]            pick_grant;
  logic                  pick_idx;
  logic                  owner_idx;

  state_e                state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [1:0]            grant_q, grant_d;
  logic                  last_q, last_d;
  logic [1:0]            done_q, done_d;
  logic [BUS_W-1:0]      mem_address_q, mem_address_d;
  logic [BUS_W-1:0]      mem_data_out_q, mem_data_out_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [1:0][BUS_W-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  assign rd_n     = {m1_rd, m0_rd};
  assign wr_n     = {m1_wr, m0_wr};
  assign addr_in  = {m1_address, m0_address};
  assign wdata_in = {m1_data_out, m0_data_out};

  // Ready is the only combinational output: an idle master is never stalled.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign req[gi]      = ~rd_n[gi] | ~wr_n[gi];
      assign both_low[gi] = ~rd_n[gi] & ~wr_n[gi];
    end
  endgenerate

  assign m0_ready = ~req[M_CORE] | done_q[M_CORE];
  assign m1_ready = ~req[M_LOADER] | done_q[M_LOADER];

  tiny16_rr_pick u_pick (
    .req        (req),
    .last       (last_q),
    .fixed_prio (FIXED_PRIO),
    .grant      (pick_grant)
  );

  assign pick_idx  = pick_grant[M_LOADER];
  assign owner_idx = grant_q[M_LOADER];

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    grant_d        = grant_q;
    last_d         = last_q;
    done_d         = done_q;
    mem_address_d  = mem_address_q;
    mem_data_out_d = mem_data_out_q;
    mem_rd_d       = mem_rd_q;
    mem_wr_d       = mem_wr_q;
    rdata_d        = rdata_q;
    err_d          = err_q;

    case (state_q)
      ST_IDLE: begin
        if (|both_low) begin
          err_d = 1'b1;
        end
        if (|req) begin
          state_d        = ST_ACCESS;
          grant_d        = idx_onehot(pick_idx);
          last_d         = pick_idx;
          mem_address_d  = addr_in[pick_idx];
          mem_data_out_d = wdata_in[pick_idx];
          wait_d         = WAIT_LOAD;
          // A conflicting rd+wr pair is resolved as a write.
          if (!wr_n[pick_idx]) begin
            mem_wr_d = 1'b0;
          end else begin
            mem_rd_d = 1'b0;
          end
        end
      end

      ST_ACCESS: begin
        if (wait_q == 4'd0) begin
          if (!mem_rd_q) begin
            rdata_d[owner_idx] = mem_data_in;
          end
          mem_rd_d = 1'b1;
          mem_wr_d = 1'b1;
          done_d   = grant_q;
          state_d  = ST_DONE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      ST_DONE: begin
        done_d  = 2'b00;
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        mem_rd_d = 1'b1;
        mem_wr_d = 1'b1;
        done_d   = 2'b00;
        grant_d  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      wait_q         <= 4'd0;
      grant_q        <= 2'b00;
      last_q         <= 1'b1;
      done_q         <= 2'b00;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
      mem_rd_q       <= 1'b1;
      mem_wr_q       <= 1'b1;
      rdata_q        <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      grant_q        <= grant_d;
      last_q         <= last_d;
      done_q         <= done_d;
      mem_address_q  <= mem_address_d;
      mem_data_out_q <= mem_data_out_d;
      mem_rd_q       <= mem_rd_d;
      mem_wr_q       <= mem_wr_d;
      rdata_q        <= rdata_d;
      err_q          <= err_d;
    end
  end

  assign m0_data_in   = rdata_q[M_CORE];
  assign m1_data_in   = rdata_q[M_LOADER];
  assign mem_address  = mem_address_q;
  assign mem_data_out = mem_data_out_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign grant        = grant_q;
  assign err          = err_q;

endmodule
